// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Memory stage of the RV64I/Zba five-stage pipeline
//
// Purpose:
//   Performs aligned B/H/W/D loads and stores to data memory over a
//   req/ack bus. It formats load data and holds the pipeline with stall_M
//   while an access is outstanding. Non-memory instructions pass through
//   with no added latency.
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   When the macro is defined, a BUSY access that gets no dmem_ack within
//   TIMEOUT_CYCLES cycles is aborted. The load result is 0, and bus_err_M
//   pulses high for the DONE cycle.
//   When the macro is undefined, BUSY waits indefinitely and bus_err_M is
//   tied to 0.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   ALUResult_M   effective address (or ALU result for non-memory ops)
//   WriteData_M   store operand
//   Funct3_M      access size/sign: 000 B, 001 H, 010 W, 011 D,
//                 100 BU, 101 HU, 110 WU
//   ResultSrc_M   2'b01 marks a load
//   MemWrite_M    marks a store
//   dmem_*        data-memory request bus (req/we/addr/wdata/be out,
//                 ack/rdata in)
//   ReadData_M    formatted load result for the MW register
//   stall_M       freezes PC/FD/DE/EM and holds MW
//   misalign_M    combinational misaligned-access flag
//   bus_err_M     timeout pulse (MEM_TIMEOUT_EN only)

module mem_stage #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] ALUResult_M,
   input  logic [63:0] WriteData_M,
   input  logic [2:0]  Funct3_M,
   input  logic [1:0]  ResultSrc_M,
   input  logic        MemWrite_M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic [63:0] ReadData_M,
   output logic        stall_M,
   output logic        misalign_M,
   output logic        bus_err_M
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] rdata_q;
   logic [63:0] shifted;
   logic [63:0] load_fmt;
   logic [63:0] store_wdata;
   logic [7:0]  store_be;
   logic [2:0]  k;
   logic        mem_op;
   logic        misaligned;
   logic        tmo_hit;

   assign k      = ALUResult_M[2:0];
   assign mem_op = (ResultSrc_M == 2'b01) | MemWrite_M;

   // Funct3[1:0] encodes the size for both signed and unsigned variants.
   always_comb begin
      misaligned = 1'b0;
      case (Funct3_M[1:0])
         2'b01:   misaligned = k[0];
         2'b10:   misaligned = |k[1:0];
         2'b11:   misaligned = |k;
         default: misaligned = 1'b0;
      endcase
   end

   // Bring the addressed byte down to lane 0, then extend it.
   assign shifted = dmem_rdata >> {k, 3'b000};

   always_comb begin
      load_fmt = 64'd0;
      case (Funct3_M)
         3'b000:  load_fmt = {{56{shifted[7]}},  shifted[7:0]};
         3'b001:  load_fmt = {{48{shifted[15]}}, shifted[15:0]};
         3'b010:  load_fmt = {{32{shifted[31]}}, shifted[31:0]};
         3'b011:  load_fmt = shifted;
         3'b100:  load_fmt = {56'd0, shifted[7:0]};
         3'b101:  load_fmt = {48'd0, shifted[15:0]};
         3'b110:  load_fmt = {32'd0, shifted[31:0]};
         default: load_fmt = 64'd0;
      endcase
   end

   // Store data is replicated across all lanes, so the byte enables alone
   // select the target bytes. Loads present the same lane mask.
   always_comb begin
      store_wdata = WriteData_M;
      store_be    = 8'hFF;
      case (Funct3_M[1:0])
         2'b00: begin
            store_wdata = {8{WriteData_M[7:0]}};
            store_be    = 8'h01 << k;
         end
         2'b01: begin
            store_wdata = {4{WriteData_M[15:0]}};
            store_be    = 8'h03 << k;
         end
         2'b10: begin
            store_wdata = {2{WriteData_M[31:0]}};
            store_be    = 8'h0F << k;
         end
         default: begin
            store_wdata = WriteData_M;
            store_be    = 8'hFF;
         end
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] tmo_cnt;
   logic          err_q;

   assign tmo_hit = (state == BUSY) && !dmem_ack &&
                    (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   // The counter is held at zero outside BUSY, so it starts from zero on
   // every entry to BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= tmo_hit;
         if (state != BUSY)
            tmo_cnt <= '0;
         else if (!dmem_ack)
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign bus_err_M = (state == DONE) & err_q & ~rst;
`else
   assign tmo_hit   = 1'b0;
   assign bus_err_M = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rdata_q <= 64'd0;
      end else begin
         state <= state_nxt;
         if (state == BUSY) begin
            if (dmem_ack)
               rdata_q <= MemWrite_M ? 64'd0 : load_fmt;
            else if (tmo_hit)
               rdata_q <= 64'd0;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      stall_M    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 64'd0;
      dmem_wdata = 64'd0;
      dmem_be    = 8'h00;
      ReadData_M = 64'd0;
      case (state)
         IDLE: begin
            if (mem_op && !misaligned) begin
               state_nxt = BUSY;
               stall_M   = 1'b1;
            end
         end
         BUSY: begin
            // The EM register is frozen, so the bus fields stay stable
            // until the ack arrives.
            stall_M    = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = MemWrite_M;
            dmem_addr  = {ALUResult_M[63:3], 3'b000};
            dmem_wdata = store_wdata;
            dmem_be    = store_be;
            if (dmem_ack || tmo_hit)
               state_nxt = DONE;
         end
         DONE: begin
            ReadData_M = rdata_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset has to silence the outputs immediately. Otherwise an
      // instruction still sitting in EM would raise stall_M from IDLE.
      if (rst) begin
         stall_M    = 1'b0;
         dmem_req   = 1'b0;
         dmem_we    = 1'b0;
         dmem_addr  = 64'd0;
         dmem_wdata = 64'd0;
         dmem_be    = 8'h00;
         ReadData_M = 64'd0;
      end
   end

   assign misalign_M = mem_op & misaligned & ~rst;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage

module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic [63:0] ALUResult_M;
   logic [63:0] WriteData_M;
   logic [2:0]  Funct3_M;
   logic [1:0]  ResultSrc_M;
   logic        MemWrite_M;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic [63:0] ReadData_M;
   logic        stall_M;
   logic        misalign_M;
   logic        bus_err_M;

   int checks   = 0;
   int failures = 0;

   // Observations captured by the access task.
   int          n_stall;
   int          n_err;
   int          n_req;
   logic        saw_done;
   logic        first_req;
   logic [63:0] rd_done;
   logic [63:0] addr_first, addr_last, wdata_first, wdata_last;
   logic [7:0]  be_first, be_last;
   logic        we_first;
   int          bad;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .ALUResult_M (ALUResult_M),
      .WriteData_M (WriteData_M),
      .Funct3_M    (Funct3_M),
      .ResultSrc_M (ResultSrc_M),
      .MemWrite_M  (MemWrite_M),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_be     (dmem_be),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .ReadData_M  (ReadData_M),
      .stall_M     (stall_M),
      .misalign_M  (misalign_M),
      .bus_err_M   (bus_err_M)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_nop(input logic [63:0] alu);
      ALUResult_M = alu;
      WriteData_M = 64'd0;
      Funct3_M    = 3'b000;
      ResultSrc_M = 2'b00;
      MemWrite_M  = 1'b0;
   endtask

   task automatic set_load(input logic [63:0] a, input logic [2:0] f3);
      ALUResult_M = a;
      WriteData_M = 64'd0;
      Funct3_M    = f3;
      ResultSrc_M = 2'b01;
      MemWrite_M  = 1'b0;
   endtask

   task automatic set_store(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] f3);
      ALUResult_M = a;
      WriteData_M = wd;
      Funct3_M    = f3;
      ResultSrc_M = 2'b00;
      MemWrite_M  = 1'b1;
   endtask

   // Runs one memory op whose inputs are already applied (called just after
   // a posedge). The ack is raised in BUSY cycle number ack_at, or never
   // if ack_at is 0. Returns after the DONE cycle.
   task automatic access(input int ack_at, input logic [63:0] rdata, input bit clear);
      n_stall  = 0;
      n_err    = 0;
      n_req    = 0;
      saw_done = 1'b0;
      rd_done  = 64'd0;
      dmem_rdata = rdata;
      for (int c = 0; c < 40 && !saw_done; c++) begin
         @(negedge clk);
         if (c == 0) first_req = dmem_req;
         if (bus_err_M) n_err++;
         if (stall_M) n_stall++;
         if (dmem_req) begin
            n_req++;
            if (n_req == 1) begin
               addr_first = dmem_addr; wdata_first = dmem_wdata;
               be_first = dmem_be; we_first = dmem_we;
            end
            addr_last = dmem_addr; wdata_last = dmem_wdata; be_last = dmem_be;
            dmem_ack = (n_req == ack_at);
         end else begin
            dmem_ack = 1'b0;
         end
         if (!stall_M && n_stall > 0) begin
            saw_done = 1'b1;
            rd_done  = ReadData_M;
         end
         @(posedge clk);
         #1 dmem_ack = 1'b0;
      end
      if (clear) set_nop(64'd0);
   endtask

   initial begin
      rst = 1'b1;
      dmem_ack = 1'b0;
      dmem_rdata = 64'd0;
      set_load(64'h1003, 3'b000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall",    stall_M, 0);
      check("rst_req",      dmem_req, 0);
      check("rst_be",       dmem_be, 0);
      check("rst_readdata", ReadData_M, 0);
      check("rst_misalign", misalign_M, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      set_nop(64'h55);
      @(posedge clk);
      #1;

      // LB 0x1003, ack in the first BUSY cycle.
      set_load(64'h1003, 3'b000);
      access(1, 64'h00000000_80000000, 1);
      check("lb_done",   saw_done, 1);
      check("lb_stall",  n_stall, 2);
      check("lb_data",   rd_done, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_addr",   addr_first, 64'h1000);
      check("lb_we",     we_first, 0);

      // LWU 0x2004, ack in the third BUSY cycle.
      set_load(64'h2004, 3'b110);
      access(3, 64'hDEADBEEF_00000000, 1);
      check("lwu_stall", n_stall, 4);
      check("lwu_data",  rd_done, 64'h0000_0000_DEAD_BEEF);

      // SH 0x3006, bus fields held across two BUSY cycles.
      set_store(64'h3006, 64'h1234, 3'b001);
      access(2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      check("sh_stall",  n_stall, 3);
      check("sh_we",     we_first, 1);
      check("sh_addr",   addr_first, 64'h3000);
      check("sh_be",     be_first, 8'hC0);
      check("sh_wdata",  wdata_first, 64'h1234123412341234);
      check("sh_hold_addr",  addr_last, 64'h3000);
      check("sh_hold_be",    be_last, 8'hC0);
      check("sh_hold_wdata", wdata_last, 64'h1234123412341234);
      check("sh_readdata",   rd_done, 0);

      // SB and SD lanes.
      set_store(64'h5005, 64'hFFFF_FFFF_FFFF_FFAB, 3'b000);
      access(1, 64'd0, 1);
      check("sb_be",    be_first, 8'h20);
      check("sb_wdata", wdata_first, 64'hABABABABABABABAB);
      set_store(64'h7000, 64'h0123456789ABCDEF, 3'b011);
      access(1, 64'd0, 1);
      check("sd_be",    be_first, 8'hFF);
      check("sd_wdata", wdata_first, 64'h0123456789ABCDEF);

      // More load formats.
      set_load(64'h6002, 3'b101);
      access(1, 64'h00000000_F00D0000, 1);
      check("lhu_data", rd_done, 64'h0000_0000_0000_F00D);
      set_load(64'h8000, 3'b010);
      access(1, 64'h00000000_80000001, 1);
      check("lw_data",  rd_done, 64'hFFFF_FFFF_8000_0001);
      set_load(64'h9000, 3'b011);
      access(1, 64'h0123456789ABCDEF, 1);
      check("ld_data",  rd_done, 64'h0123456789ABCDEF);

      // Back-to-back loads: one IDLE cycle between the accesses.
      set_load(64'h1001, 3'b100);
      access(1, 64'h00000000_0000F100, 0);
      check("b2b_first", rd_done, 64'h0000_0000_0000_00F1);
      access(1, 64'h00000000_0000F100, 1);
      check("b2b_idle_req",  first_req, 0);
      check("b2b_second_stall", n_stall, 2);

      // Misaligned LD: no request, no stall, zero result.
      set_load(64'h4004, 3'b011);
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (dmem_req || stall_M || ReadData_M != 0 || !misalign_M) bad++;
         @(posedge clk);
         #1;
      end
      check("misalign_ld", bad, 0);
      set_nop(64'd0);

      // A stray ack outside BUSY is ignored.
      dmem_ack = 1'b1;
      bad = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (dmem_req || stall_M || ReadData_M != 0) bad++;
         @(posedge clk);
         #1;
      end
      dmem_ack = 1'b0;
      check("stray_ack", bad, 0);

      // Reset in the second BUSY cycle.
      set_load(64'h1003, 3'b000);
      n_req = 0;
      for (int c = 0; c < 10 && n_req < 2; c++) begin
         @(negedge clk);
         if (dmem_req) n_req++;
      end
      check("rst_mid_reached", n_req, 2);
      rst = 1'b1;
      #1;
      check("rst_mid_req",   dmem_req, 0);
      check("rst_mid_stall", stall_M, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_nop(64'h42);
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (dmem_req || stall_M || ReadData_M != 0) bad++;
         @(posedge clk);
         #1;
      end
      check("add_after_rst", bad, 0);
      // A load after the reset completes normally from IDLE.
      set_load(64'h1003, 3'b000);
      access(1, 64'h00000000_80000000, 1);
      check("lb_after_rst", rd_done, 64'hFFFF_FFFF_FFFF_FF80);
      check("no_bus_err",   n_err, 0);

`ifdef MEM_TIMEOUT_EN
      set_load(64'hA000, 3'b011);
      access(0, 64'h1111, 1);
      check("tmo_done",  saw_done, 1);
      check("tmo_stall", n_stall, 5);
      check("tmo_err",   n_err, 1);
      check("tmo_data",  rd_done, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
